// File: rtl/signed_accumulator.sv
// ============================================================================
// Module   : signed_accumulator
// Purpose  : Sums N_TERMS signed operands, then presents the result until it
//            is taken; ACCUM_SAT_EN selects clamping, otherwise truncation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module signed_accumulator #(
  parameter int IN_W    = 16,
  parameter int ACC_W   = 28,
  parameter int OUT_W   = 16,
  parameter int N_TERMS = 784
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_ovf
);

  localparam int CNT_W = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(N_TERMS - 1);

  generate
    if (OUT_W > ACC_W) begin : g_chk_out_w
      $error("signed_accumulator: OUT_W must not exceed ACC_W");
    end
    if (IN_W > ACC_W) begin : g_chk_in_w
      $error("signed_accumulator: IN_W must not exceed ACC_W");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   res_q, res_d;

  logic signed [ACC_W-1:0] w_in_ext;
  logic [ACC_W-1:0]        w_sum;
  logic [OUT_W-1:0]        w_res;
  logic                    w_ovf;
  logic                    w_final_beat;

  assign w_in_ext     = ACC_W'($signed(in_data));
  assign w_sum        = acc_q + w_in_ext;
  assign w_final_beat = (state_q == ST_ACCUM) && in_valid && (cnt_q == C_LAST_CNT);

`ifdef ACCUM_SAT_EN
  // Result fits iff every bit from the OUT_W sign bit upward agrees.
  logic [ACC_W-OUT_W:0] w_top;
  logic                 ovf_q;

  assign w_top = w_sum[ACC_W-1:OUT_W-1];
  assign w_ovf = !((&w_top) || !(|w_top));
  assign w_res = !w_ovf           ? w_sum[OUT_W-1:0] :
                 w_sum[ACC_W-1]   ? {1'b1, {(OUT_W-1){1'b0}}} :
                                    {1'b0, {(OUT_W-1){1'b1}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (w_final_beat) begin
      ovf_q <= w_ovf;
    end
  end

  assign out_ovf = ovf_q;
`else
  assign w_ovf   = 1'b0;
  assign w_res   = w_sum[OUT_W-1:0];
  assign out_ovf = w_ovf;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      ST_ACCUM: begin
        if (in_valid) begin
          acc_d = w_sum;
          cnt_d = cnt_q + CNT_W'(1);
          if (w_final_beat) begin
            state_d = ST_DONE;
            res_d   = w_res;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  // Handshake outputs are forced low for the whole time rst is held.
  assign in_ready  = (state_q == ST_ACCUM) && !rst;
  assign out_valid = (state_q == ST_DONE) && !rst;
  assign out_data  = res_q;

endmodule

`default_nettype wire

// File: tb/tb_signed_accumulator.sv
// ============================================================================
// Module   : tb_signed_accumulator
// Purpose  : Self-checking bench for signed_accumulator (N_TERMS=4, ACC_W=20).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_signed_accumulator;

  localparam int IN_W    = 16;
  localparam int ACC_W   = 20;
  localparam int OUT_W   = 16;
  localparam int N_TERMS = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_ovf;

  signed_accumulator #(
    .IN_W   (IN_W),
    .ACC_W  (ACC_W),
    .OUT_W  (OUT_W),
    .N_TERMS(N_TERMS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  int               m_cnt     = 0;
  longint           m_sum     = 0;
  bit               m_has     = 1'b0;
  logic [OUT_W-1:0] m_data    = '0;
  bit               m_ovf     = 1'b0;
  int               m_results = 0;
  bit               chk_en    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected result of a plain integer sum, after ACC_W wrap and output mapping.
  function automatic void expect_of(input longint sum, output logic [OUT_W-1:0] d, output bit o);
    longint a;
    longint hi;
    longint lo;
    a  = sum & ((64'sd1 <<< ACC_W) - 1);
    if (a >= (64'sd1 <<< (ACC_W - 1))) a = a - (64'sd1 <<< ACC_W);
    hi = (64'sd1 <<< (OUT_W - 1)) - 1;
    lo = -(64'sd1 <<< (OUT_W - 1));
`ifdef ACCUM_SAT_EN
    if (a > hi) begin
      d = OUT_W'(hi); o = 1'b1;
    end else if (a < lo) begin
      d = OUT_W'(lo); o = 1'b1;
    end else begin
      d = OUT_W'(a); o = 1'b0;
    end
`else
    d = OUT_W'(a);
    o = 1'b0;
`endif
  endfunction

  // Reference: count accepted beats, keep their integer sum.
  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_sum = 0; m_has = 1'b0;
    end else if (m_has) begin
      if (out_ready) begin
        m_has = 1'b0; m_cnt = 0; m_sum = 0; m_results++;
      end
    end else if (in_valid) begin
      m_sum = m_sum + longint'($signed(in_data));
      m_cnt++;
      if (m_cnt == N_TERMS) begin
        m_has = 1'b1;
        expect_of(m_sum, m_data, m_ovf);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(!rst && !m_has));
      chk("out_valid", 32'(out_valid), 32'(!rst && m_has));
      if (!rst && m_has) begin
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_ovf", 32'(out_ovf), 32'(m_ovf));
      end
    end
  end

  task automatic beat(input int v);
    in_valid = 1'b1;
    in_data  = IN_W'(v);
    @(negedge clk);
  endtask

  task automatic wait_res(input string name, input logic [OUT_W-1:0] exp_d, input bit exp_o);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      chk({name, "_timeout"}, 32'(out_valid), 32'd1);
    end else begin
      chk({name, "_data"}, 32'(out_data), 32'(exp_d));
      chk({name, "_ovf"}, 32'(out_ovf), 32'(exp_o));
    end
  endtask

  initial begin
    int target;
    int guard;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk_en = 1'b1;
    rst    = 1'b0;
    #1;
    chk("rst_release_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Basic sum with latency: result visible one cycle after the last beat.
    out_ready = 1'b1;
    beat(100); beat(-50); beat(7); beat(1);
    in_valid = 1'b0;
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_data", 32'(out_data), 32'd58);
    chk("basic_ovf", 32'(out_ovf), 32'd0);
    @(negedge clk);
    chk("basic_one_cycle", 32'(out_valid), 32'd0);

    repeat (4) beat(32767);
    in_valid = 1'b0;
`ifdef ACCUM_SAT_EN
    wait_res("pos_clamp", 16'h7FFF, 1'b1);
`else
    wait_res("pos_wrap", 16'hFFFC, 1'b0);
`endif
    @(negedge clk);

    repeat (4) beat(-32768);
    in_valid = 1'b0;
`ifdef ACCUM_SAT_EN
    wait_res("neg_clamp", 16'h8000, 1'b1);
`else
    wait_res("neg_wrap", 16'h0000, 1'b0);
`endif
    @(negedge clk);

    // Back-pressure: result holds, in_valid during DONE is ignored.
    out_ready = 1'b0;
    beat(1); beat(2); beat(3); beat(4);
    in_data = IN_W'(5);
    wait_res("hold_first", 16'd10, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("hold_data", 32'(out_data), 32'd10);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    wait_res("after_hold", 16'd20, 1'b0);
    @(negedge clk);

    // Reset mid-accumulation discards the partial sum.
    beat(1); beat(2);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    beat(1); beat(2); beat(3); beat(4);
    in_valid = 1'b0;
    wait_res("mid_rst_sum", 16'd10, 1'b0);
    @(negedge clk);

    // Random traffic with gaps, back-pressure, extremes and rare resets.
    target = m_results + 1000;
    guard  = 0;
    while (m_results < target && guard < 40000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       in_data = 16'h7FFF;
        1:       in_data = 16'h8000;
        default: in_data = IN_W'($urandom);
      endcase
      out_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 999) == 0);
      @(negedge clk);
      guard++;
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("random_progress", 32'(m_results >= target), 32'd1);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
